// File: rtl/fa_pipe_adder.sv
// Pipelined WIDTH-bit add/subtract unit. The carry ripples through SEG-bit
// segments with one register stage per segment, behind a valid/ready handshake.
module fa_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ov
);
  localparam int STAGES = WIDTH / SEG;
  localparam int MID    = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int BFWD_W = (STAGES > 1) ? SEG * (STAGES - 1) * STAGES / 2 : 1;

  logic              adv;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [WIDTH-1:0]  s_q;
  logic              co_q;
  logic              ov_q;

  // Between stages, the unconsumed upper A bits and the resolved lower sum bits
  // share one word. Unconsumed B slices travel in a triangular bus with one
  // shrinking field per stage.
  logic [MID-1:0][WIDTH-1:0] as_fwd;
  logic [MID-1:0]            c_fwd;
  logic [BFWD_W-1:0]         b_fwd;

  assign out_valid = valid_q[STAGES-1];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign valid_d   = STAGES'({valid_q, in_valid});
  assign s         = s_q;
  assign co        = co_q;
  assign ov        = ov_q;

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // the values its upstream neighbour held before this clock edge.
  always_ff @(posedge ck) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (adv) begin
      valid_q <= valid_d;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO   = k * SEG;
    localparam int B_IN = WIDTH - LO;

    logic [WIDTH-1:0] as_in;
    logic [WIDTH-1:0] as_d;
    logic [B_IN-1:0]  b_in;
    logic             c_in;
    logic [SEG:0]     slice_d;

    if (k == 0) begin : g_src
      assign as_in = a;
      assign b_in  = sub ? ~b : b;
      assign c_in  = sub ? 1'b1 : ci;
    end else begin : g_chain
      localparam int OFF = SEG * ((k - 1) * (STAGES - 1) - ((k - 1) * (k - 2)) / 2);
      assign as_in = as_fwd[k-1];
      assign b_in  = b_fwd[OFF +: B_IN];
      assign c_in  = c_fwd[k-1];
    end

    // NOTE: as_d takes a full default before the slice overwrite, so this
    // block never holds a previous value and cannot infer a latch.
    always_comb begin
      slice_d         = {1'b0, as_in[LO +: SEG]} + {1'b0, b_in[SEG-1:0]} + {{SEG{1'b0}}, c_in};
      as_d            = as_in;
      as_d[LO +: SEG] = slice_d[SEG-1:0];
    end

    if (k < STAGES - 1) begin : g_mid
      localparam int OFF = SEG * (k * (STAGES - 1) - (k * (k - 1)) / 2);
      logic [WIDTH-1:0]    as_q;
      logic [B_IN-SEG-1:0] b_q;
      logic                c_q;

      // NOTE: the operand/partial-sum registers carry no reset. The valid bits
      // decide what reaches the output, so stale data here is never observed.
      always_ff @(posedge ck) begin
        if (adv) begin
          as_q <= as_d;
          b_q  <= b_in[B_IN-1:SEG];
          c_q  <= slice_d[SEG];
        end
      end

      assign as_fwd[k]               = as_q;
      assign b_fwd[OFF +: B_IN - SEG] = b_q;
      assign c_fwd[k]                = c_q;
    end else begin : g_last
      logic msb_cin;
      // Carry into the MSB, recovered from the MSB sum bit: sum = a ^ b ^ cin.
      assign msb_cin = as_in[WIDTH-1] ^ b_in[SEG-1] ^ as_d[WIDTH-1];

      always_ff @(posedge ck) begin
        if (!rst) begin
          s_q  <= '0;
          co_q <= 1'b0;
          ov_q <= 1'b0;
        end else if (adv) begin
          s_q  <= as_d;
          co_q <= slice_d[SEG];
          ov_q <= msb_cin ^ slice_d[SEG];
        end
      end
    end
  end

endmodule

// File: tb/tb_fa_pipe_adder.sv
// Self-checking bench for fa_pipe_adder (WIDTH=16, SEG=4): directed vector table,
// streaming with and without backpressure, and reset while beats are in flight.
module tb_fa_pipe_adder;
  localparam int WIDTH = 16;
  localparam int SEG   = 4;
  localparam int LAT   = 4;

  logic             ck        = 1'b0;
  logic             rst       = 1'b0;
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic             sub       = 1'b0;
  logic [WIDTH-1:0] a         = '0;
  logic [WIDTH-1:0] b         = '0;
  logic             ci        = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ov;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vecs [12];

  fa_pipe_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .ck        (ck),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .co        (co),
    .ov        (ov)
  );

  always #5 ck = ~ck;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference result packed as {ov, co, s}.
  function automatic logic [17:0] model(input logic sb, input logic [15:0] x,
                                        input logic [15:0] y, input logic c);
    logic [15:0] ye;
    logic [16:0] r;
    logic        v;
    ye = sb ? ~y : y;
    r  = {1'b0, x} + {1'b0, ye} + {16'b0, (sb ? 1'b1 : c)};
    v  = (x[15] == ye[15]) && (r[15] != x[15]);
    return {v, r};
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    @(negedge ck);
    out_ready = 1'b1;
    sub       = v.sub;
    a         = v.a;
    b         = v.b;
    ci        = v.ci;
    in_valid  = 1'b1;
    #1 check({tag, "_in_ready"}, in_ready, 1);
    @(negedge ck);
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 20) begin
      @(negedge ck);
      lat++;
    end
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_s"}, s, v.s);
    check({tag, "_co"}, co, v.co);
    check({tag, "_ov"}, ov, v.ov);
  endtask

  task automatic run_stream(input int n, input logic [3:0] rdy_pat, input string tag,
                            output int cycles);
    logic [17:0] expq[$];
    logic [17:0] held;
    logic [17:0] exp_r;
    logic [15:0] xa;
    logic [15:0] xb;
    logic        stalled;
    int          sent;
    int          rcvd;
    int          cyc;
    sent    = 0;
    rcvd    = 0;
    cyc     = 0;
    stalled = 1'b0;
    held    = '0;
    while (rcvd < n && cyc < 200) begin
      @(negedge ck);
      out_ready = rdy_pat[cyc % 4];
      #1;
      check({tag, "_in_ready"}, in_ready, (!out_valid || out_ready));
      if (stalled) check({tag, "_hold"}, {out_valid, ov, co, s}, {1'b1, held});
      stalled = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          check({tag, "_not_extra"}, (expq.size() > 0), 1);
          if (expq.size() > 0) begin
            exp_r = expq.pop_front();
            check({tag, "_result"}, {ov, co, s}, exp_r);
            rcvd++;
          end
        end else begin
          stalled = 1'b1;
          held    = {ov, co, s};
        end
      end
      if (sent < n) begin
        xa       = 16'(32'h1357 * sent + 32'h00F1);
        xb       = 16'(32'h2468 * sent + 32'h0F0E);
        sub      = sent[0];
        ci       = sent[1];
        a        = xa;
        b        = xb;
        in_valid = 1'b1;
        if (in_ready) begin
          expq.push_back(model(sent[0], xa, xb, sent[1]));
          sent++;
        end
      end else begin
        in_valid = 1'b0;
      end
      cyc++;
    end
    in_valid = 1'b0;
    check({tag, "_received"}, rcvd, n);
    check({tag, "_queue_empty"}, expq.size(), 0);
    cycles = cyc;
  endtask

  initial begin
    int   cyc;
    int   seen;
    vec_t nv;

    vecs[0]  = '{1'b0, 16'h1234, 16'h1111, 1'b1, 16'h2346, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[5]  = '{1'b1, 16'h0010, 16'h0010, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b0, 1'b1};

    // Reset held for two rising edges.
    rst = 1'b0;
    repeat (2) @(negedge ck);
    check("rst_out_valid", out_valid, 0);
    check("rst_s", s, 0);
    check("rst_co", co, 0);
    check("rst_ov", ov, 0);
    rst = 1'b1;
    #1 check("rst_release_in_ready", in_ready, 1);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    run_stream(8, 4'b1111, "stream", cyc);
    check("stream_cycles", cyc, 8 + LAT);

    run_stream(8, 4'b1001, "bp", cyc);

    // Reset while three beats are in flight.
    @(negedge ck);
    out_ready = 1'b1;
    sub       = 1'b0;
    ci        = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a        = 16'(i + 1);
      b        = 16'h0100;
      in_valid = 1'b1;
      #1 check("mr_accept", in_ready, 1);
      @(negedge ck);
    end
    in_valid = 1'b0;
    rst      = 1'b0;
    @(negedge ck);
    rst = 1'b1;
    check("mr_out_valid_after_rst", out_valid, 0);
    seen = 0;
    repeat (8) begin
      @(negedge ck);
      if (out_valid) seen++;
    end
    check("mr_no_stale", seen, 0);
    nv = '{1'b0, 16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0, 1'b0};
    run_vec(nv, "mr_new");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
